addsub_pipe: RTL



---
 rtl/addsub_pkg.sv | 21 ++
 rtl/addsub_pipe_if.sv | 29 ++
 rtl/addsub_chunk.sv | 18 +
 rtl/addsub_pipe.sv | 130 +++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared types and helpers for the pipelined add/subtract unit.
package addsub_pkg;

   typedef enum logic [1:0] {
      OP_ADD = 2'd0,
      OP_SUB = 2'd1,
      OP_ADC = 2'd2,
      OP_SBB = 2'd3
   } op_t;

   localparam int SAT_MAX_W = 64;

   // Clamp pattern for a width-bit result: 0111..1 for positive, 1000..0 for negative.
   function automatic logic [SAT_MAX_W-1:0] sat_value(input logic sign, input int width);
      logic [SAT_MAX_W-1:0] v;
      for (int i = 0; i < SAT_MAX_W; i++)
         v[i] = (i < width - 1) ? ~sign : ((i == width - 1) ? sign : 1'b0);
      return v;
   endfunction

endpackage

// File: rtl/addsub_pipe_if.sv
// Operand/result handshake bundle between the read stage and writeback.
interface addsub_pipe_if #(parameter int WIDTH = 16);
   import addsub_pkg::*;

   logic             In_Valid;
   logic             In_Ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   op_t              Op;
   logic             Cin;
   logic             Sat_En;
   logic             Out_Valid;
   logic             Out_Ready;
   logic [WIDTH:0]   S;
   logic             Cout;
   logic             Ovf;
   logic             Zero;
   logic             Neg;

   modport master (
      output In_Valid, A, B, Op, Cin, Sat_En, Out_Ready,
      input  In_Ready, Out_Valid, S, Cout, Ovf, Zero, Neg
   );

   modport slave (
      input  In_Valid, A, B, Op, Cin, Sat_En, Out_Ready,
      output In_Ready, Out_Valid, S, Cout, Ovf, Zero, Neg
   );
endinterface

// File: rtl/addsub_chunk.sv
// One CW-bit slice of the carry chain; c_msb_o feeds the signed-overflow test.
module addsub_chunk #(
   parameter int CW = 8
) (
   input  logic [CW-1:0] a_i,
   input  logic [CW-1:0] b_i,
   input  logic          cin_i,
   output logic [CW-1:0] sum_o,
   output logic          cout_o,
   output logic          c_msb_o
);
   logic [CW:0] full;

   assign full    = {1'b0, a_i} + {1'b0, b_i} + {{CW{1'b0}}, cin_i};
   assign sum_o   = full[CW-1:0];
   assign cout_o  = full[CW];
   assign c_msb_o = a_i[CW-1] ^ b_i[CW-1] ^ full[CW-1];
endmodule

// File: rtl/addsub_pipe.sv
// Pipelined add/sub: chunk k of the carry chain resolves in stage k; the last stage
// registers the saturated result and flags as the output register.
module addsub_pipe
   import addsub_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int CHUNKS = 2
) (
   input logic          Clk,
   input logic          Reset,
   addsub_pipe_if.slave bus
);
   localparam int CW = WIDTH / CHUNKS;

   logic             advance;
   logic             inv_b;
   logic             out_valid_q;
   logic [WIDTH:0]   s_q;
   logic             cout_q, ovf_q, zero_q, neg_q;

   // Per-stage inputs: operands (skew), partial result (deskew), carry, sat, valid.
   logic [CHUNKS-1:0][WIDTH-1:0] si_a, si_b, si_r;
   logic [CHUNKS-1:0]            si_c, si_sat, si_v;

   assign advance      = !out_valid_q || bus.Out_Ready;
   assign bus.In_Ready = advance;

   assign inv_b     = (bus.Op == OP_SUB) || (bus.Op == OP_SBB);
   assign si_a[0]   = bus.A;
   assign si_b[0]   = inv_b ? ~bus.B : bus.B;
   assign si_c[0]   = (bus.Op == OP_ADD) ? 1'b0 : (bus.Op == OP_SUB) ? 1'b1 : bus.Cin;
   assign si_r[0]   = '0;
   assign si_sat[0] = bus.Sat_En;
   assign si_v[0]   = bus.In_Valid;

   for (genvar k = 0; k < CHUNKS; k++) begin : g_stage
      logic [CW-1:0]    sum;
      logic             cout, c_msb;
      logic [WIDTH-1:0] r_d;

      addsub_chunk #(.CW(CW)) u_chunk (
         .a_i    (si_a[k][k*CW +: CW]),
         .b_i    (si_b[k][k*CW +: CW]),
         .cin_i  (si_c[k]),
         .sum_o  (sum),
         .cout_o (cout),
         .c_msb_o(c_msb)
      );

      // Upper chunks of si_r are still zero, so OR drops the new chunk in place.
      assign r_d = si_r[k] | (WIDTH'(sum) << (k * CW));

      if (k < CHUNKS - 1) begin : g_mid
         logic [WIDTH-1:0] a_q, b_q, r_q;
         logic             c_q, sat_q, v_q;
         logic             unused_cmsb;

         assign unused_cmsb = c_msb;

         always_ff @(posedge Clk) begin
            if (Reset) begin
               a_q   <= '0;
               b_q   <= '0;
               r_q   <= '0;
               c_q   <= 1'b0;
               sat_q <= 1'b0;
               v_q   <= 1'b0;
            end else if (advance) begin
               a_q   <= si_a[k];
               b_q   <= si_b[k];
               r_q   <= r_d;
               c_q   <= cout;
               sat_q <= si_sat[k];
               v_q   <= si_v[k];
            end
         end

         assign si_a[k+1]   = a_q;
         assign si_b[k+1]   = b_q;
         assign si_r[k+1]   = r_q;
         assign si_c[k+1]   = c_q;
         assign si_sat[k+1] = sat_q;
         assign si_v[k+1]   = v_q;
      end else begin : g_last
         logic                 ovf;
         logic [SAT_MAX_W-1:0] sat_pat;
         logic [WIDTH-1:0]     res;
         logic [WIDTH:0]       s_d;
         logic                 cout_d, ovf_d, zero_d, neg_d;
         logic                 unused_bits;

         assign ovf         = cout ^ c_msb;
         assign sat_pat     = sat_value(si_a[k][WIDTH-1], WIDTH);
         assign res         = (si_sat[k] && ovf) ? sat_pat[WIDTH-1:0] : r_d;
         assign unused_bits = ^{si_a[k], si_b[k], sat_pat};

         // Bubbles load zeros so an idle output reads 0.
         assign s_d    = si_v[k] ? {res[WIDTH-1], res} : '0;
         assign cout_d = si_v[k] & cout;
         assign ovf_d  = si_v[k] & ovf;
         assign zero_d = si_v[k] & (res == '0);
         assign neg_d  = si_v[k] & res[WIDTH-1];

         always_ff @(posedge Clk) begin
            if (Reset) begin
               out_valid_q <= 1'b0;
               s_q         <= '0;
               cout_q      <= 1'b0;
               ovf_q       <= 1'b0;
               zero_q      <= 1'b0;
               neg_q       <= 1'b0;
            end else if (advance) begin
               out_valid_q <= si_v[k];
               s_q         <= s_d;
               cout_q      <= cout_d;
               ovf_q       <= ovf_d;
               zero_q      <= zero_d;
               neg_q       <= neg_d;
            end
         end
      end
   end

   assign bus.Out_Valid = out_valid_q;
   assign bus.S         = s_q;
   assign bus.Cout      = cout_q;
   assign bus.Ovf       = ovf_q;
   assign bus.Zero      = zero_q;
   assign bus.Neg       = neg_q;
endmodule
